// File: rtl/if_stage_pc_ifid_if.sv
// rtl/if_stage_pc_ifid_if.sv - fetch-stage signal bundle between PC/IF-ID block and its surroundings
interface if_stage_pc_ifid_if;
  // next-PC mux chain, hazard unit and instruction memory towards the fetch stage
  logic [31:0] next_pc_in;
  logic        redirect;
  logic        pc_write;
  logic        ifid_write;
  logic [31:0] instr_in;

  // fetch stage towards instruction memory, first jump mux and decode
  logic [31:0] imem_addr;
  logic [31:0] pc_out;
  logic [31:0] pc_plus_4;
  logic [31:0] ifid_pc_plus_4;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        misalign_err;
  logic [31:0] fetch_count;

  // surrounding pipeline logic
  modport master (
    output next_pc_in,
    output redirect,
    output pc_write,
    output ifid_write,
    output instr_in,
    input  imem_addr,
    input  pc_out,
    input  pc_plus_4,
    input  ifid_pc_plus_4,
    input  ifid_instr,
    input  ifid_valid,
    input  misalign_err,
    input  fetch_count
  );

  // the fetch stage itself
  modport slave (
    input  next_pc_in,
    input  redirect,
    input  pc_write,
    input  ifid_write,
    input  instr_in,
    output imem_addr,
    output pc_out,
    output pc_plus_4,
    output ifid_pc_plus_4,
    output ifid_instr,
    output ifid_valid,
    output misalign_err,
    output fetch_count
  );
endinterface

// File: rtl/if_stage_pc_ifid.sv
// rtl/if_stage_pc_ifid.sv - PC register, PC+4 adder and IF/ID pipeline register with flush bubble
module if_stage_pc_ifid #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic              Clk,
  input  logic              Reset,
  if_stage_pc_ifid_if.slave bus
);

  logic [31:0] pc_q;
  logic [31:0] pc_plus_4;
  logic [31:0] ifid_instr_q;
  logic [31:0] ifid_pc_plus_4_q;
  logic        ifid_valid_q;
  logic        misalign_q;
  logic [31:0] fetch_count_q;
  logic        capture;

  // Wraps modulo 2^32 so 0xFFFF_FFFC rolls over to zero.
  assign pc_plus_4 = pc_q + 32'd4;

  // A real instruction enters ID only when IF/ID loads and no redirect squashes it.
  assign capture = bus.ifid_write && !bus.redirect;

  // PC register: the low two bits of the target are dropped so fetch stays word aligned.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q <= RESET_PC;
    end else if (bus.pc_write) begin
      pc_q <= {bus.next_pc_in[31:2], 2'b00};
    end
  end

  // Sticky flag recording that an unaligned target was accepted at least once.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      misalign_q <= 1'b0;
    end else if (bus.pc_write && (bus.next_pc_in[1:0] != 2'b00)) begin
      misalign_q <= 1'b1;
    end
  end

  // IF/ID register: a stall holds everything, even across a redirect, since a
  // stalled ID will resolve the same branch again next cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ifid_instr_q     <= NOP_INSTR;
      ifid_pc_plus_4_q <= 32'd0;
      ifid_valid_q     <= 1'b0;
    end else if (bus.ifid_write) begin
      if (bus.redirect) begin
        ifid_instr_q     <= NOP_INSTR;
        ifid_pc_plus_4_q <= 32'd0;
        ifid_valid_q     <= 1'b0;
      end else begin
        ifid_instr_q     <= bus.instr_in;
        ifid_pc_plus_4_q <= pc_plus_4;
        ifid_valid_q     <= 1'b1;
      end
    end
  end

  // Counts real instructions handed to decode; wraps silently.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fetch_count_q <= 32'd0;
    end else if (capture) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign bus.imem_addr      = pc_q;
  assign bus.pc_out         = pc_q;
  assign bus.pc_plus_4      = pc_plus_4;
  assign bus.ifid_pc_plus_4 = ifid_pc_plus_4_q;
  assign bus.ifid_instr     = ifid_instr_q;
  assign bus.ifid_valid     = ifid_valid_q;
  assign bus.misalign_err   = misalign_q;
  assign bus.fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_if_stage_pc_ifid.sv
// tb/tb_if_stage_pc_ifid.sv - self-checking bench for the fetch-stage PC and IF/ID register
module tb_if_stage_pc_ifid;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  logic Clk;
  logic Reset;

  if_stage_pc_ifid_if bus ();

  if_stage_pc_ifid #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // instruction memory contents: word at address a holds 0x1000 + a
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0000_1000 + a;
  endfunction

  // combinational instruction memory read
  always_comb bus.instr_in = mem_word(bus.imem_addr);

  int tests_run = 0;
  int tests_failed = 0;

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic        m_mis;
  logic [31:0] m_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_instr = NOP_INSTR;
    m_pc4   = 32'd0;
    m_valid = 1'b0;
    m_mis   = 1'b0;
    m_count = 32'd0;
  endtask

  // one clock: drive inputs at negedge, advance model at the edge, compare after it
  task automatic cyc(input logic r, input logic rd, input logic pw, input logic iw,
                     input logic [31:0] npc);
    logic [31:0] old_pc;
    @(negedge Clk);
    Reset          = r;
    bus.redirect   = rd;
    bus.pc_write   = pw;
    bus.ifid_write = iw;
    bus.next_pc_in = npc;
    check("imem_addr", bus.imem_addr, m_pc);
    check("pc_plus_4", bus.pc_plus_4, m_pc + 32'd4);
    @(posedge Clk);
    old_pc = m_pc;
    if (r) begin
      model_reset();
    end else begin
      if (pw) begin
        m_pc = npc & 32'hFFFF_FFFC;
        if (npc % 4 != 0) m_mis = 1'b1;
      end
      if (iw && rd) begin
        m_instr = NOP_INSTR;
        m_pc4   = 32'd0;
        m_valid = 1'b0;
      end else if (iw) begin
        m_instr = mem_word(old_pc);
        m_pc4   = old_pc + 32'd4;
        m_valid = 1'b1;
        m_count = m_count + 1;
      end
    end
    #1;
    check("pc_out", bus.pc_out, m_pc);
    check("ifid_instr", bus.ifid_instr, m_instr);
    check("ifid_pc_plus_4", bus.ifid_pc_plus_4, m_pc4);
    check("ifid_valid", {31'd0, bus.ifid_valid}, {31'd0, m_valid});
    check("misalign_err", {31'd0, bus.misalign_err}, {31'd0, m_mis});
    check("fetch_count", bus.fetch_count, m_count);
  endtask

  task automatic seq_step();
    cyc(1'b0, 1'b0, 1'b1, 1'b1, m_pc + 32'd4);
  endtask

  logic [31:0] hold_instr;
  logic [31:0] hold_pc4;
  logic [31:0] hold_count;

  initial begin
    model_reset();
    Reset          = 1'b1;
    bus.redirect   = 1'b0;
    bus.pc_write   = 1'b1;
    bus.ifid_write = 1'b1;
    bus.next_pc_in = 32'h0000_0040;

    // reset state
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0040);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0080);
    check("rst_pc", bus.pc_out, RESET_PC);
    check("rst_valid", {31'd0, bus.ifid_valid}, 32'd0);
    check("rst_count", bus.fetch_count, 32'd0);

    // sequential fetch
    seq_step();
    check("seq_pc4", bus.pc_out, 32'h4);
    check("seq_instr0", bus.ifid_instr, 32'h1000);
    seq_step();
    seq_step();
    check("seq_pc12", bus.pc_out, 32'hC);
    check("seq_instr2", bus.ifid_instr, 32'h1008);
    check("seq_count3", bus.fetch_count, 32'd3);

    // load-use stall at 0x20
    while (m_pc != 32'h20) seq_step();
    hold_instr = bus.ifid_instr;
    hold_pc4   = bus.ifid_pc_plus_4;
    hold_count = bus.fetch_count;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0500);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0504);
    check("stall_pc", bus.pc_out, 32'h20);
    check("stall_instr", bus.ifid_instr, hold_instr);
    check("stall_pc4", bus.ifid_pc_plus_4, hold_pc4);
    check("stall_count", bus.fetch_count, hold_count);

    // branch redirect at 0x40
    while (m_pc != 32'h40) seq_step();
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0100);
    check("br_pc", bus.pc_out, 32'h100);
    check("br_flush_instr", bus.ifid_instr, NOP_INSTR);
    check("br_flush_valid", {31'd0, bus.ifid_valid}, 32'd0);
    seq_step();
    check("br_target_instr", bus.ifid_instr, 32'h1100);
    check("br_target_pc4", bus.ifid_pc_plus_4, 32'h104);

    // stall coinciding with redirect: nothing happens until the stall lifts
    hold_instr = bus.ifid_instr;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0200);
    check("sr_pc_hold", bus.pc_out, 32'h104);
    check("sr_instr_hold", bus.ifid_instr, hold_instr);
    check("sr_valid_hold", {31'd0, bus.ifid_valid}, 32'd1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
    check("sr_pc", bus.pc_out, 32'h200);
    check("sr_valid", {31'd0, bus.ifid_valid}, 32'd0);

    // misaligned jr target
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0106);
    check("mis_pc", bus.pc_out, 32'h104);
    check("mis_flag", {31'd0, bus.misalign_err}, 32'd1);
    for (int i = 0; i < 10; i++) seq_step();
    check("mis_sticky", {31'd0, bus.misalign_err}, 32'd1);

    // wrap of the PC adder
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    check("wrap_pc", bus.pc_out, 32'hFFFF_FFFC);
    seq_step();
    check("wrap_pc0", bus.pc_out, 32'h0);
    check("wrap_ifid_pc4", bus.ifid_pc_plus_4, 32'h0);

    // reset during a redirect
    seq_step();
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0300);
    check("mrst_pc", bus.pc_out, RESET_PC);
    check("mrst_valid", {31'd0, bus.ifid_valid}, 32'd0);
    check("mrst_mis", {31'd0, bus.misalign_err}, 32'd0);
    check("mrst_count", bus.fetch_count, 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic        r, rd, pw, iw;
      logic [31:0] npc;
      r  = ($urandom_range(0, 49) == 0);
      rd = ($urandom_range(0, 3) == 0);
      pw = ($urandom_range(0, 4) != 0);
      iw = ($urandom_range(0, 3) == 0) ? ~pw : pw;
      if ($urandom_range(0, 3) == 0)
        npc = $urandom;
      else if (rd)
        npc = $urandom & 32'h0000_FFFC;
      else
        npc = m_pc + 32'd4;
      cyc(r, rd, pw, iw, npc);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/if_stage_pc_ifid.md
Name: if_stage_pc_ifid

Overview:
- Fetch-stage front end: PC register, PC+4 adder and IF/ID pipeline register.
- Consumes the final next-PC value from the jump/branch mux chain (branch, jal, jr) and the hazard unit's stall controls.
- Produces PC+4 for the first jump/branch mux, the instruction-memory address, and the IF/ID register contents consumed by decode.
- Also generates the IF/ID flush bubble on control redirects.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, encoding inserted into IF/ID on flush or reset (sll $0,$0,0).

Ports:
Clk  input  1  system clock, rising-edge.
Reset  input  1  synchronous, active-high reset.
next_pc_in  input  32  next PC from third jump/branch mux.
redirect  input  1  taken branch OR jump OR jr resolved in ID this cycle.
pc_write  input  1  hazard unit: 1 = PC may update, 0 = hold (load-use stall).
ifid_write  input  1  hazard unit: 1 = IF/ID may load, 0 = hold.
instr_in  input  32  instruction-memory read data for imem_addr (combinational read).
imem_addr  output  32  equals pc_out.
pc_out  output  32  current PC register.
pc_plus_4  output  32  pc_out + 4, feeds first jump/branch mux In1_PC_plus_4.
ifid_pc_plus_4  output  32  registered PC+4 of the instruction in ID.
ifid_instr  output  32  registered instruction in ID.
ifid_valid  output  1  1 = ifid_instr is a real fetched instruction, 0 = bubble.
misalign_err  output  1  sticky: a non-word-aligned next_pc_in was accepted.
fetch_count  output  32  number of valid instructions captured into IF/ID since reset.

Behaviour:
- Clocking: single clock domain. Every register updates only on the rising edge of Clk.
- Reset, synchronous, dominating all other inputs including mid-stream:
  - pc_out = RESET_PC
  - ifid_instr = NOP_INSTR, ifid_pc_plus_4 = 0, ifid_valid = 0
  - misalign_err = 0, fetch_count = 0
- pc_plus_4: combinational, pc_out + 32'd4, modulo 2^32 (0xFFFF_FFFC + 4 = 0x0000_0000). imem_addr = pc_out, combinational.
- PC update, evaluated each edge when Reset = 0:
  - pc_write = 1: pc_out <= {next_pc_in[31:2], 2'b00}.
  - pc_write = 0: pc_out holds.
- Alignment:
  - If pc_write = 1 and next_pc_in[1:0] != 0, set misalign_err to 1. It stays 1 until Reset.
  - The PC still loads the aligned value.
- IF/ID update, in priority order (Reset first):
  1. ifid_write = 0: hold all IF/ID fields. A concurrent redirect is ignored, because a stalled ID re-evaluates the branch next cycle.
  2. ifid_write = 1 and redirect = 1 (flush): ifid_instr <= NOP_INSTR, ifid_pc_plus_4 <= 0, ifid_valid <= 0.
  3. ifid_write = 1 and redirect = 0: ifid_instr <= instr_in, ifid_pc_plus_4 <= pc_plus_4, ifid_valid <= 1.
- fetch_count: increments by 1 (wrapping) on every edge taking case 3. It is unchanged otherwise.
- Latency:
  - The instruction at PC A in cycle N appears on ifid_instr after edge N+1.
  - A redirect asserted in cycle N loads next_pc_in at edge N+1 and squashes the one wrong-path instruction fetched in cycle N.
- pc_write and ifid_write are independent inputs. The hazard unit normally drives them equal; mismatched combinations follow the rules above with no extra interlock.
- No combinational path from redirect, pc_write or ifid_write to any output.

Test Plan:
- Reset then 4 cycles, RESET_PC = 0, next_pc_in = pc_plus_4, instr_in = 0x1000+addr:
  - pc_out sequence is 0, 4, 8, 12.
  - ifid_instr is 0x1000, 0x1004, 0x1008 with ifid_valid = 1.
  - fetch_count = 3.
- Load-use stall with pc = 0x20, pc_write = ifid_write = 0 for 2 cycles:
  - pc_out stays 0x20.
  - ifid_instr and ifid_pc_plus_4 unchanged.
  - fetch_count unchanged.
- Branch redirect with pc = 0x40, redirect = 1, next_pc_in = 0x100:
  - After the edge, pc_out = 0x100, ifid_instr = NOP_INSTR, ifid_valid = 0.
  - The next cycle captures instr_in at 0x100 with ifid_pc_plus_4 = 0x104.
- Simultaneous stall and redirect (pc_write = ifid_write = 0, redirect = 1, next_pc_in = 0x200):
  - PC and IF/ID hold.
  - No flush.
  - The following cycle with stall released performs the redirect.
- Misaligned jr target next_pc_in = 0x0000_0106 with pc_write = 1:
  - pc_out = 0x104.
  - misalign_err = 1, and it remains 1 through 10 further normal cycles.
- Wrap and reset:
  - pc_out = 0xFFFF_FFFC gives pc_plus_4 = 0; after the edge, pc_out = 0.
  - Reset asserted mid-stream during a redirect: pc_out = RESET_PC, ifid_valid = 0, misalign_err = 0, fetch_count = 0 after the edge.
